// File: rtl/backprop_layer_stack.sv
// LIFO of per-(layer,row) backprop operands: filled during the forward pass,
// replayed highest layer first with rows descending over a valid/ready port.
module backprop_layer_stack #(
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int max_layer_size = 4,
  parameter int max_row_size   = 4,
  parameter int index_width    = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2*index_width+1:0]  backprop_controll_bundle,
  input  logic [data_size*size-1:0] diff_to_all,
  input  logic [data_size*size-1:0] diff_dense,
  input  logic [data_size*size-1:0] diff_cost,
  input  logic [data_size*size-1:0] diff_start,
  input  logic                      out_ready,
  output logic [data_size*size-1:0] diff_to_all_out,
  output logic [data_size*size-1:0] diff_dense_out,
  output logic [data_size*size-1:0] diff_cost_out,
  output logic [data_size*size-1:0] diff_start_out,
  output logic [index_width-1:0]    current_layer_out,
  output logic [index_width-1:0]    current_row_out,
  output logic                      read_update_data,
  output logic                      start_new_layer,
  output logic                      is_last_layer,
  output logic                      active_train,
  output logic                      overflow,
  output logic                      done
);
  localparam int VW  = data_size*size;
  localparam int EW  = 4*VW;
  localparam int ENT = max_layer_size*max_row_size;
  localparam int LW  = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int RW  = $clog2(max_row_size+1);
  localparam int AW  = (ENT > 1) ? $clog2(ENT) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, EMIT, DONE} state_t;

  typedef struct packed {
    logic                   is_store;
    logic                   start_train;
    logic [index_width-1:0] layer;
    logic [index_width-1:0] row;
  } ctrl_t;

  ctrl_t                             ctrl;
  state_t                            state_q;
  logic [LW-1:0]                     cur_layer_q, top_q;
  logic [RW-1:0]                     cur_row_q;
  logic [max_layer_size-1:0][RW-1:0] rows_q;
  logic [ENT-1:0]                    valid_q;
  logic [EW-1:0]                     mem_q [ENT];

  logic          in_range, st_en, wr_en, any_valid, nxt_found;
  logic [LW-1:0] st_layer, nxt_layer;
  logic [RW-1:0] st_rows;
  logic [AW-1:0] st_addr, rd_addr;

  assign ctrl      = ctrl_t'(backprop_controll_bundle);
  assign in_range  = (ctrl.layer < index_width'(max_layer_size)) &&
                     (ctrl.row < index_width'(max_row_size));
  assign st_en     = (state_q == IDLE) && ctrl.is_store;
  assign wr_en     = st_en && in_range;
  assign st_layer  = LW'(ctrl.layer);
  assign st_rows   = RW'(ctrl.row) + RW'(1);
  assign st_addr   = AW'(st_layer) * AW'(max_row_size) + AW'(ctrl.row);
  assign rd_addr   = AW'(cur_layer_q) * AW'(max_row_size) + AW'(cur_row_q);
  // A store coinciding with start_train counts toward the empty check.
  assign any_valid = (|valid_q) || wr_en;

  // Highest layer below the current one that holds any rows.
  always_comb begin
    nxt_found = 1'b0;
    nxt_layer = '0;
    for (int i = 0; i < max_layer_size; i++) begin
      if ((LW'(i) < cur_layer_q) && (rows_q[i] != '0)) begin
        nxt_found = 1'b1;
        nxt_layer = LW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[st_addr] <= {diff_to_all, diff_dense, diff_cost, diff_start};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cur_layer_q       <= '0;
      cur_row_q         <= '0;
      top_q             <= '0;
      rows_q            <= '0;
      valid_q           <= '0;
      {diff_to_all_out, diff_dense_out, diff_cost_out, diff_start_out} <= '0;
      current_layer_out <= '0;
      current_row_out   <= '0;
      read_update_data  <= 1'b0;
      start_new_layer   <= 1'b0;
      is_last_layer     <= 1'b0;
      active_train      <= 1'b0;
      overflow          <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_en) begin
            valid_q[st_addr] <= 1'b1;
            if (st_rows > rows_q[st_layer]) rows_q[st_layer] <= st_rows;
            if (st_layer > top_q) top_q <= st_layer;
          end
          if (st_en && !in_range) overflow <= 1'b1;
          if (ctrl.start_train) begin
            if (any_valid) begin
              state_q      <= SETUP;
              active_train <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        // Reads top_q/rows_q after any same-edge store has landed.
        SETUP: begin
          cur_layer_q <= top_q;
          cur_row_q   <= rows_q[top_q] - RW'(1);
          state_q     <= LOAD;
        end
        LOAD: begin
          {diff_to_all_out, diff_dense_out, diff_cost_out, diff_start_out} <=
            valid_q[rd_addr] ? mem_q[rd_addr] : '0;
          current_layer_out <= index_width'(cur_layer_q);
          current_row_out   <= index_width'(cur_row_q);
          start_new_layer   <= (cur_row_q == rows_q[cur_layer_q] - RW'(1));
          is_last_layer     <= (cur_layer_q == '0);
          read_update_data  <= 1'b1;
          state_q           <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            read_update_data <= 1'b0;
            start_new_layer  <= 1'b0;
            is_last_layer    <= 1'b0;
            if (cur_row_q != '0) begin
              cur_row_q <= cur_row_q - RW'(1);
              state_q   <= LOAD;
            end else if (nxt_found) begin
              cur_layer_q <= nxt_layer;
              cur_row_q   <= rows_q[nxt_layer] - RW'(1);
              state_q     <= LOAD;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done         <= 1'b1;
          active_train <= 1'b0;
          valid_q      <= '0;
          rows_q       <= '0;
          top_q        <= '0;
          overflow     <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
